// File: rtl/writeback.sv
// Writeback stage: holds one instruction from the memory stage, waits for load
// data when needed, aligns/extends it, drives the regfile write port, counts retirement.
//
// Ports:
//   clk, reset (async, active-low)
//   valid_in, rd_address_in, result_in, is_load_in, load_size_in, load_signed_in
//                            : instruction from the memory stage
//   mem_rsp_valid, mem_rsp_data : load response word from data memory
//   stall_out                : hold the memory stage while a load waits
//   rd_address, rd_data      : regfile write port (address 0 = no write)
//   retired, instret         : commit pulse and running retired count
module writeback #(
    parameter int INSTRET_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic [4:0]               rd_address_in,
    input  logic [31:0]              result_in,
    input  logic                     is_load_in,
    input  logic [1:0]               load_size_in,
    input  logic                     load_signed_in,
    input  logic                     mem_rsp_valid,
    input  logic [31:0]              mem_rsp_data,
    output logic                     stall_out,
    output logic [4:0]               rd_address,
    output logic [31:0]              rd_data,
    output logic                     retired,
    output logic [INSTRET_WIDTH-1:0] instret
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ALU  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [INSTRET_WIDTH-1:0] INSTRET_ONE = 1;

    state_t                   state_q, state_d;
    logic [4:0]               rd_q, rd_d;
    logic [31:0]              result_q, result_d;
    logic [1:0]               load_size_q, load_size_d;
    logic                     load_signed_q, load_signed_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

    logic        commit;
    logic        stall;
    logic [1:0]  off;
    logic [31:0] shifted;
    logic [31:0] load_data;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            rd_q          <= '0;
            result_q      <= '0;
            load_size_q   <= '0;
            load_signed_q <= 1'b0;
            instret_q     <= '0;
        end else begin
            state_q       <= state_d;
            rd_q          <= rd_d;
            result_q      <= result_d;
            load_size_q   <= load_size_d;
            load_signed_q <= load_signed_d;
            instret_q     <= instret_d;
        end
    end

    // Commit / stall decode, shared by next-state and output logic
    always_comb begin
        commit = (state_q == ST_ALU) ||
                 ((state_q == ST_WAIT) && mem_rsp_valid);
        stall  = (state_q == ST_WAIT) && !mem_rsp_valid;
    end

    // Next-state logic: capture whenever not stalled, so a commit and the
    // next capture share one edge.
    always_comb begin
        state_d       = state_q;
        rd_d          = rd_q;
        result_d      = result_q;
        load_size_d   = load_size_q;
        load_signed_d = load_signed_q;
        instret_d     = instret_q;
        if (!stall) begin
            rd_d          = rd_address_in;
            result_d      = result_in;
            load_size_d   = load_size_in;
            load_signed_d = load_signed_in;
            if (!valid_in) begin
                state_d = ST_IDLE;
            end else if (is_load_in) begin
                state_d = ST_WAIT;
            end else begin
                state_d = ST_ALU;
            end
        end
        if (commit) begin
            instret_d = instret_q + INSTRET_ONE;
        end
    end

    // Load alignment and extension
    always_comb begin
        off       = result_q[1:0];
        shifted   = mem_rsp_data >> {off, 3'b000};
        load_data = mem_rsp_data;
        unique case (load_size_q)
            2'd0: load_data = {{24{load_signed_q & shifted[7]}}, shifted[7:0]};
            2'd1: begin
                // off[0] is ignored: misaligned halves read the containing half
                if (off[1]) begin
                    load_data = {{16{load_signed_q & mem_rsp_data[31]}},
                                 mem_rsp_data[31:16]};
                end else begin
                    load_data = {{16{load_signed_q & mem_rsp_data[15]}},
                                 mem_rsp_data[15:0]};
                end
            end
            default: load_data = mem_rsp_data;
        endcase
    end

    // Outputs: the write port is forced to x0 when nothing commits, since the
    // regfile writes and bypasses unconditionally.
    always_comb begin
        stall_out  = stall;
        rd_address = 5'd0;
        rd_data    = 32'd0;
        retired    = 1'b0;
        if (commit) begin
            rd_address = rd_q;
            rd_data    = (state_q == ST_WAIT) ? load_data : result_q;
            retired    = 1'b1;
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for writeback.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_writeback;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [4:0]  rd_address_in;
    logic [31:0] result_in;
    logic        is_load_in;
    logic [1:0]  load_size_in;
    logic        load_signed_in;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        stall_out;
    logic [4:0]  rd_address;
    logic [31:0] rd_data;
    logic        retired;
    logic [63:0] instret;

    int n_checks = 0;
    int n_errors = 0;

    writeback #(.INSTRET_WIDTH(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .rd_address_in  (rd_address_in),
        .result_in      (result_in),
        .is_load_in     (is_load_in),
        .load_size_in   (load_size_in),
        .load_signed_in (load_signed_in),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .stall_out      (stall_out),
        .rd_address     (rd_address),
        .rd_data        (rd_data),
        .retired        (retired),
        .instret        (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        valid_in       = 1'b0;
        rd_address_in  = 5'd0;
        result_in      = 32'd0;
        is_load_in     = 1'b0;
        load_size_in   = 2'd0;
        load_signed_in = 1'b0;
    endtask

    task automatic alu_in(input logic [4:0] rd, input logic [31:0] res);
        valid_in       = 1'b1;
        rd_address_in  = rd;
        result_in      = res;
        is_load_in     = 1'b0;
        load_size_in   = 2'd0;
        load_signed_in = 1'b0;
    endtask

    task automatic load_in(input logic [4:0] rd, input logic [31:0] addr,
                           input logic [1:0] sz, input logic sgn);
        valid_in       = 1'b1;
        rd_address_in  = rd;
        result_in      = addr;
        is_load_in     = 1'b1;
        load_size_in   = sz;
        load_signed_in = sgn;
    endtask

    task automatic commit_chk(input string tag, input logic [4:0] rd,
                              input logic [31:0] data);
        check({tag, ".rd"}, 64'(rd_address), 64'(rd));
        check({tag, ".data"}, 64'(rd_data), 64'(data));
        check({tag, ".ret"}, 64'(retired), 64'd1);
        check({tag, ".stall"}, 64'(stall_out), 64'd0);
    endtask

    task automatic quiet_chk(input string tag);
        check({tag, ".rd"}, 64'(rd_address), 64'd0);
        check({tag, ".data"}, 64'(rd_data), 64'd0);
        check({tag, ".ret"}, 64'(retired), 64'd0);
    endtask

    // One load issued into an empty stage with the response in the next cycle.
    task automatic quick_load(input string tag, input logic [31:0] addr,
                              input logic [1:0] sz, input logic sgn,
                              input logic [31:0] word, input logic [31:0] exp);
        @(negedge clk);
        load_in(5'd3, addr, sz, sgn);
        mem_rsp_valid = 1'b0;
        #1 check({tag, ".pre_stall"}, 64'(stall_out), 64'd0);
        @(negedge clk);
        idle_in();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = word;
        #1 commit_chk(tag, 5'd3, exp);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1 quiet_chk({tag, ".after"});
    endtask

    initial begin
        reset         = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        idle_in();

        // Reset state
        #2;
        check("rst.stall", 64'(stall_out), 64'd0);
        quiet_chk("rst");
        check("rst.instret", instret, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // ALU op captured at edge 1, committed in the following cycle
        @(negedge clk);
        alu_in(5'd5, 32'h1234_5678);
        #1 quiet_chk("alu.pre");
        @(negedge clk);
        idle_in();
        #1 commit_chk("alu", 5'd5, 32'h1234_5678);
        check("alu.instret0", instret, 64'd0);
        @(negedge clk);
        #1 quiet_chk("alu.after");
        check("alu.instret1", instret, 64'd1);

        // Load alignment cases, response immediately
        quick_load("lb_s",  32'h0000_1003, 2'd0, 1'b1, 32'h80FF_FFFF, 32'hFFFF_FF80);
        quick_load("lhu",   32'h0000_2002, 2'd1, 1'b0, 32'hBEEF_1234, 32'h0000_BEEF);
        quick_load("lh",    32'h0000_2002, 2'd1, 1'b1, 32'hBEEF_1234, 32'hFFFF_BEEF);
        quick_load("lbu1",  32'h0000_0001, 2'd0, 1'b0, 32'h1122_8344, 32'h0000_0083);
        quick_load("lh_lo", 32'h0000_0001, 2'd1, 1'b1, 32'h0000_9ABC, 32'hFFFF_9ABC);
        quick_load("lw3",   32'h0000_0007, 2'd3, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        check("ld.instret", instret, 64'd7);

        // Load with a 3-cycle delayed response; next ALU op held while stalled
        @(negedge clk);
        load_in(5'd7, 32'h0000_0040, 2'd2, 1'b0);
        @(negedge clk);
        alu_in(5'd9, 32'h0000_A5A5);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check($sformatf("dly.stall%0d", i), 64'(stall_out), 64'd1);
            quiet_chk($sformatf("dly.c%0d", i));
        end
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hCAFE_F00D;
        #1 commit_chk("dly", 5'd7, 32'hCAFE_F00D);
        @(negedge clk);
        idle_in();
        // Stray response while holding an ALU op must be ignored
        mem_rsp_data = 32'h5555_5555;
        #1 commit_chk("dly.next", 5'd9, 32'h0000_A5A5);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1 check("dly.instret", instret, 64'd9);

        // Asynchronous reset while a load waits
        @(negedge clk);
        load_in(5'd12, 32'h0000_0000, 2'd2, 1'b0);
        @(negedge clk);
        idle_in();
        #1 check("rw.stall_pre", 64'(stall_out), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("rw.stall", 64'(stall_out), 64'd0);
        quiet_chk("rw");
        check("rw.instret", instret, 64'd0);
        @(negedge clk);
        reset         = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h7777_7777;
        #1 quiet_chk("rw.late_rsp");
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1 check("rw.instret_after", instret, 64'd0);

        // Ten back-to-back ALU ops, rd = 0..9
        @(negedge clk);
        alu_in(5'd0, 32'h0000_0100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 9) alu_in(5'(i + 1), 32'h0000_0100 + 32'(i + 1));
            else idle_in();
            #1 commit_chk($sformatf("b2b%0d", i), 5'(i),
                          32'h0000_0100 + 32'(i));
            check($sformatf("b2b%0d.instret", i), instret, 64'(i));
        end
        @(negedge clk);
        #1 quiet_chk("b2b.after");
        check("b2b.instret", instret, 64'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
